// File: rtl/mips_pkg.sv
// Shared decode-stage constants and types: register addressing, data width, scoreboard counter.
package mips_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int XLEN         = 32;
  localparam int MAX_INFLIGHT = 3;
  localparam int SB_CNT_W     = $clog2(MAX_INFLIGHT + 1);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [SB_CNT_W-1:0]   sb_cnt_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/id_regfile_if.sv
// Decode-stage register file bundle: read ports, writeback, issue/stall handshake and debug read.
interface id_regfile_if #(
  parameter int XLEN = mips_pkg::XLEN
) ();
  logic [4:0]      rs_addr;
  logic [4:0]      rt_addr;
  logic            rs_use;
  logic            rt_use;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            issue_valid;
  logic            issue_we;
  logic [4:0]      issue_addr;
  logic            stall;
  logic            sb_err;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport slave (
    input  rs_addr, rt_addr, rs_use, rt_use, wb_we, wb_addr, wb_data,
           issue_valid, issue_we, issue_addr, dbg_addr,
    output rs_data, rt_data, stall, sb_err, dbg_data
  );

  modport master (
    output rs_addr, rt_addr, rs_use, rt_use, wb_we, wb_addr, wb_data,
           issue_valid, issue_we, issue_addr, dbg_addr,
    input  rs_data, rt_data, stall, sb_err, dbg_data
  );
endinterface

// File: rtl/id_regfile_reg_scoreboard.sv
// Per-register in-flight write counters; stall is combinational, counters and sticky sb_err update on the edge.
// REGFILE_FWD_EN lets a same-cycle writeback retire its pending count for stall purposes.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int MAX_INFLIGHT = mips_pkg::MAX_INFLIGHT
) (
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  input  logic      rs_use,
  input  logic      rt_use,
  input  logic      wb_we,
  input  reg_addr_t wb_addr,
  input  logic      issue_valid,
  input  logic      issue_we,
  input  reg_addr_t issue_addr,
  output logic      stall,
  output logic      sb_err
);
  localparam sb_cnt_t CNT_MAX = sb_cnt_t'(MAX_INFLIGHT);

  sb_cnt_t cnt_q [NUM_REGS];
  sb_cnt_t cnt_d [NUM_REGS];
  logic    sb_err_q, sb_err_d;

  logic    rs_dec, rt_dec;
  sb_cnt_t rs_eff, rt_eff;
  logic    inc_vld, dec_vld;
  logic    inc_r, dec_r;

`ifdef REGFILE_FWD_EN
  assign rs_dec = wb_we && (wb_addr == rs_addr);
  assign rt_dec = wb_we && (wb_addr == rt_addr);
`else
  assign rs_dec = 1'b0;
  assign rt_dec = 1'b0;
`endif

  // An idle counter seeing a stray writeback has nothing left to retire.
  assign rs_eff = (rs_dec && cnt_q[rs_addr] != '0) ? cnt_q[rs_addr] - sb_cnt_t'(1) : cnt_q[rs_addr];
  assign rt_eff = (rt_dec && cnt_q[rt_addr] != '0) ? cnt_q[rt_addr] - sb_cnt_t'(1) : cnt_q[rt_addr];

  assign stall = !reset && issue_valid &&
                 ((rs_use && rs_addr != REG_ZERO && rs_eff != '0) ||
                  (rt_use && rt_addr != REG_ZERO && rt_eff != '0));

  assign inc_vld = !reset && issue_valid && issue_we && !stall && issue_addr != REG_ZERO;
  assign dec_vld = !reset && wb_we && wb_addr != REG_ZERO;

  always_comb begin
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    inc_r    = 1'b0;
    dec_r    = 1'b0;
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_d[r] = '0;
      sb_err_d = 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        inc_r = inc_vld && (issue_addr == reg_addr_t'(r));
        dec_r = dec_vld && (wb_addr == reg_addr_t'(r));
        if (inc_r && !dec_r) begin
          if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
          else                     cnt_d[r] = cnt_q[r] + sb_cnt_t'(1);
        end else if (dec_r && !inc_r) begin
          if (cnt_q[r] == '0) sb_err_d = 1'b1;
          else                cnt_d[r] = cnt_q[r] - sb_cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    sb_err_q <= sb_err_d;
  end

  assign sb_err = sb_err_q;
endmodule

// File: rtl/id_regfile.sv
// Decode register file: 32 x XLEN, combinational reads, edge writes; stall from the write scoreboard.
// REGFILE_FWD_EN enables write-through bypass on rs/rt (never on the debug port).
module id_regfile
  import mips_pkg::*;
#(
  parameter int XLEN         = mips_pkg::XLEN,
  parameter int MAX_INFLIGHT = mips_pkg::MAX_INFLIGHT
) (
  input  logic         clk,
  input  logic         reset,
  id_regfile_if.slave  bus
);
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            rs_hit, rt_hit;

  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_d[r] = '0;
    end else if (bus.wb_we && bus.wb_addr != REG_ZERO) begin
      regs_d[bus.wb_addr] = bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

`ifdef REGFILE_FWD_EN
  assign rs_hit = bus.wb_we && (bus.wb_addr == bus.rs_addr);
  assign rt_hit = bus.wb_we && (bus.wb_addr == bus.rt_addr);
`else
  assign rs_hit = 1'b0;
  assign rt_hit = 1'b0;
`endif

  assign bus.rs_data  = (reset || bus.rs_addr == REG_ZERO) ? '0 :
                        rs_hit ? bus.wb_data : regs_q[bus.rs_addr];
  assign bus.rt_data  = (reset || bus.rt_addr == REG_ZERO) ? '0 :
                        rt_hit ? bus.wb_data : regs_q[bus.rt_addr];
  assign bus.dbg_data = (reset || bus.dbg_addr == REG_ZERO) ? '0 : regs_q[bus.dbg_addr];

  reg_scoreboard #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .rs_addr     (bus.rs_addr),
    .rt_addr     (bus.rt_addr),
    .rs_use      (bus.rs_use),
    .rt_use      (bus.rt_use),
    .wb_we       (bus.wb_we),
    .wb_addr     (bus.wb_addr),
    .issue_valid (bus.issue_valid),
    .issue_we    (bus.issue_we),
    .issue_addr  (bus.issue_addr),
    .stall       (bus.stall),
    .sb_err      (bus.sb_err)
  );
endmodule

// File: tb/tb_id_regfile.sv
// Bench for id_regfile: directed vector table, then randomized pipeline traffic against a reference model.
module tb_id_regfile;
  localparam int XL = 32;
`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_regfile_if #(.XLEN(XL)) bus ();
  id_regfile #(.XLEN(XL)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit rst; logic [4:0] rs; logic [4:0] rt; bit rsu; bit rtu;
    bit we; logic [4:0] wa; logic [31:0] wd;
    bit iv; bit iwe; logic [4:0] ia; logic [4:0] dbg;
    logic [31:0] ers; logic [31:0] ert; logic [31:0] edbg; bit est; bit eerr;
  } vec_t;
  vec_t tv[$];

  task automatic drive(input bit rst, input logic [4:0] rs, input logic [4:0] rt, input bit rsu,
                       input bit rtu, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit iv, input bit iwe, input logic [4:0] ia, input logic [4:0] dbg);
    reset = rst; bus.rs_addr = rs; bus.rt_addr = rt; bus.rs_use = rsu; bus.rt_use = rtu;
    bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd;
    bus.issue_valid = iv; bus.issue_we = iwe; bus.issue_addr = ia; bus.dbg_addr = dbg;
  endtask

  // Reference model: architectural registers plus an outstanding-write count per register.
  logic [XL-1:0] m_regs [32];
  int            m_cnt  [32];
  bit            m_err;

  function automatic logic [XL-1:0] m_read(input int a, input bit bypass);
    if (reset || a == 0) return '0;
    if (bypass && FWD && bus.wb_we && int'(bus.wb_addr) == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic int m_pending(input int a);
    int e = m_cnt[a];
    if (FWD && bus.wb_we && int'(bus.wb_addr) == a && e > 0) e--;
    return e;
  endfunction

  function automatic bit m_stall();
    int rs = int'(bus.rs_addr);
    int rt = int'(bus.rt_addr);
    if (reset || !bus.issue_valid) return 1'b0;
    return (bus.rs_use && rs != 0 && m_pending(rs) != 0) ||
           (bus.rt_use && rt != 0 && m_pending(rt) != 0);
  endfunction

  task automatic m_step();
    int inc_a, dec_a;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
      m_err = 1'b0;
      return;
    end
    inc_a = (bus.issue_valid && bus.issue_we && !m_stall() && bus.issue_addr != 0) ? int'(bus.issue_addr) : -1;
    dec_a = (bus.wb_we && bus.wb_addr != 0) ? int'(bus.wb_addr) : -1;
    if (dec_a > 0) m_regs[dec_a] = bus.wb_data;
    if (inc_a > 0 && inc_a != dec_a) begin
      if (m_cnt[inc_a] == 3) m_err = 1'b1; else m_cnt[inc_a]++;
    end
    if (dec_a > 0 && dec_a != inc_a) begin
      if (m_cnt[dec_a] == 0) m_err = 1'b1; else m_cnt[dec_a]--;
    end
  endtask

  bit          p_we [3];
  logic [4:0]  p_a  [3];
  logic [31:0] p_d  [3];

  initial begin
    logic [31:0] D, A;
    bit acc;
    logic [31:0] nd;
    D = 32'hDEADBEEF;
    A = 32'hA5A5A5A5;

    tv.push_back('{1, 5, 0, 1, 0, 1, 5, 32'h111, 1, 1, 5, 5, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 5, 0, 0, 0, 1, 5, D, 0, 0, 0, 5, FWD ? D : 32'h0, 0, 0, 0, 0});
    tv.push_back('{0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, D, 0, D, 0, 0});
    tv.push_back('{0, 0, 0, 1, 0, 1, 0, 32'h1234, 1, 1, 7, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 7, 0, 0, 1, 7, A, 0, 0, 0, 7, 0, FWD ? A : 32'h0, 0, 0, 0});
    tv.push_back('{0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, A, A, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0});
    tv.push_back('{0, 0, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0});
    tv.push_back('{0, 3, 0, 1, 0, 1, 3, 32'h33, 1, 0, 0, 3, FWD ? 32'h33 : 32'h0, 0, 0, !FWD, 0});
    tv.push_back('{0, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 3, 32'h33, 0, 32'h33, 0, 0});
    for (int k = 0; k < 4; k++) tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 9, 0, 1, 0, 1, 9, 32'h99, 1, 0, 0, 0, FWD ? 32'h99 : 32'h0, 0, 0, 1, 1});
    tv.push_back('{0, 9, 0, 1, 0, 1, 9, 32'h99, 1, 0, 0, 0, 32'h99, 0, 0, 1, 1});
    tv.push_back('{0, 9, 0, 1, 0, 1, 9, 32'h99, 1, 0, 0, 0, 32'h99, 0, 0, !FWD, 1});
    tv.push_back('{0, 9, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h99, 0, 0, 0, 1});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1});
    tv.push_back('{1, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0});

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].rs, tv[i].rt, tv[i].rsu, tv[i].rtu, tv[i].we, tv[i].wa, tv[i].wd,
            tv[i].iv, tv[i].iwe, tv[i].ia, tv[i].dbg);
      @(negedge clk);
      chk($sformatf("vec%0d rs_data", i), bus.rs_data, tv[i].ers);
      chk($sformatf("vec%0d rt_data", i), bus.rt_data, tv[i].ert);
      chk($sformatf("vec%0d dbg_data", i), bus.dbg_data, tv[i].edbg);
      chk($sformatf("vec%0d stall", i), {31'b0, bus.stall}, {31'b0, tv[i].est});
      chk($sformatf("vec%0d sb_err", i), {31'b0, bus.sb_err}, {31'b0, tv[i].eerr});
      @(posedge clk); #1;
    end

    // Random pipeline traffic: accepted writers reach WB three cycles after issue.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); m_step(); #1;
    for (int s = 0; s < 3; s++) begin p_we[s] = 1'b0; p_a[s] = '0; p_d[s] = '0; end
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            p_we[2], p_a[2], p_d[2],
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      if (c > 1500 && !p_we[2] && $urandom_range(0, 29) == 0) begin
        bus.wb_we = 1'b1; bus.wb_addr = 5'($urandom_range(0, 31)); bus.wb_data = $urandom;
      end
      @(negedge clk);
      chk("rnd stall", {31'b0, bus.stall}, {31'b0, m_stall()});
      chk("rnd rs_data", bus.rs_data, m_read(int'(bus.rs_addr), 1'b1));
      chk("rnd rt_data", bus.rt_data, m_read(int'(bus.rt_addr), 1'b1));
      chk("rnd dbg_data", bus.dbg_data, m_read(int'(bus.dbg_addr), 1'b0));
      chk("rnd sb_err", {31'b0, bus.sb_err}, {31'b0, m_err});
      @(posedge clk);
      acc = !reset && bus.issue_valid && bus.issue_we && !m_stall();
      nd = $urandom;
      m_step();
      if (reset) begin
        for (int s = 0; s < 3; s++) p_we[s] = 1'b0;
      end else begin
        p_we[2] = p_we[1]; p_a[2] = p_a[1]; p_d[2] = p_d[1];
        p_we[1] = p_we[0]; p_a[1] = p_a[0]; p_d[1] = p_d[0];
        p_we[0] = acc;     p_a[0] = bus.issue_addr; p_d[0] = nd;
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_regfile.md
Name: id_regfile

Overview:
- Decode-stage register file; receiving end of the writeback interface driven by the WB stage (regWrite, write register, write data).
- Provides two combinational read ports for rs/rt, with a write-through bypass.
- Contains a per-register in-flight write scoreboard that raises a stall toward the ID/EX pipeline register when a source operand is still being produced downstream.

Parameters:
- XLEN, 32, data width of each register.
- MAX_INFLIGHT, 3, maximum outstanding writes per register (EX, MEM, WB); sets counter width to 2 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- rs_addr  input  5  read port A address
- rt_addr  input  5  read port B address
- rs_use  input  1  instruction in ID reads rs
- rt_use  input  1  instruction in ID reads rt
- rs_data  output  XLEN  read port A data
- rt_data  output  XLEN  read port B data
- wb_we  input  1  writeback write enable (WB regWrite)
- wb_addr  input  5  writeback destination register
- wb_data  input  XLEN  writeback data
- issue_valid  input  1  instruction in ID is attempting to advance to EX
- issue_we  input  1  that instruction writes a register
- issue_addr  input  5  its destination register
- stall  output  1  hold ID, inject bubble into EX
- sb_err  output  1  sticky scoreboard over/underflow flag
- dbg_addr  input  5  debug read address
- dbg_data  output  XLEN  debug read data (array contents, no bypass)

Behaviour:
- Storage: 32 x XLEN registers.
  - r0 reads 0 always.
  - Writes to r0 are discarded and never touch the scoreboard.
- Write: on a rising edge with wb_we=1 and wb_addr!=0, regs[wb_addr] <= wb_data.
- Read: combinational.
  - Returns 0 if the address is 0.
  - Otherwise returns wb_data if wb_we=1 and wb_addr matches (bypass, see feature).
  - Otherwise returns regs[addr].
- Scoreboard: 2-bit counter cnt[r] per register r=1..31.
  - inc = issue_valid & issue_we & !stall & issue_addr==r.
  - dec = wb_we & wb_addr==r.
  - inc&dec: counter unchanged. inc only: +1. dec only: -1.
- Effective pending: eff(r) = cnt[r] - (dec this cycle for r ? 1 : 0) when bypass is enabled, otherwise eff(r) = cnt[r].
- stall = issue_valid & ((rs_use & rs_addr!=0 & eff(rs)!=0) | (rt_use & rt_addr!=0 & eff(rt)!=0)). Combinational, no latency.
- A stalled issue does not increment any counter; the instruction is re-presented next cycle.
- Boundary conditions:
  - inc with cnt=3: counter saturates at 3; sb_err set.
  - dec with cnt=0: counter stays 0; sb_err set; the register write still happens.
  - sb_err clears only on reset.
- Reset, applied on the clock edge while reset=1:
  - All 31 registers cleared to 0.
  - All counters cleared to 0.
  - sb_err=0.
- While reset=1:
  - stall forced 0.
  - rs_data/rt_data/dbg_data forced 0.
  - Writes and issues are ignored.
- Reset asserted mid-stall: the stall drops in that cycle and all pending state is lost, because the pipeline is flushed by the same reset.

Optional Feature:
- Macro: REGFILE_FWD_EN.
- Defined:
  - The write-through bypass is active on rs_data/rt_data.
  - A same-cycle WB write to a source retires its pending count for stall purposes.
  - A dependency resolves in the WB cycle.
- Undefined:
  - Reads return array contents only.
  - eff(r)=cnt[r], so the stall persists through the WB cycle and releases one cycle later.
  - Adds one bubble per RAW hazard.
- dbg_data never bypasses in either build.

Decomposition:
- Shared package mips_pkg:
  - REG_ADDR_W=5
  - NUM_REGS=32
  - XLEN default
  - REG_ZERO=5'd0
  - typedef for the scoreboard counter
- One sub-module, reg_scoreboard: counters, eff/stall logic and sb_err.
- The top module holds the array, read muxes and bypass.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 (wb_we=1, wb_addr=5); next cycle rs_addr=5 -> rs_data=0xDEADBEEF, dbg_data=0xDEADBEEF.
- wb_we=1, wb_addr=0, wb_data=0x1234 -> rs_addr=0 reads 0; cnt unchanged; sb_err=0.
- FWD_EN: same-cycle wb_we=1, wb_addr=7, wb_data=0xA5A5A5A5 with rt_addr=7 -> rt_data=0xA5A5A5A5 that cycle, dbg_data on r7 still old value.
- Issue writer of r3 (issue_we=1, addr=3), then a reader with rs_addr=3, rs_use=1 -> stall=1 for the EX and MEM cycles; stall=0 in the WB cycle with FWD_EN, one cycle later without it.
- Four back-to-back accepted issues to r9 with no WB -> cnt=3 after the third; the fourth sets sb_err=1 and cnt stays 3.
- r2 pending (cnt=1), assert reset for one cycle -> stall=0 immediately; after reset, rs_addr=2 reads 0 with no stall; sb_err=0.
